// File: rtl/ads_pkg.sv
// Shared definitions for the ads population counter and its serial front end.
// Frame width, fill-index width and fill-side state encoding.
package ads_pkg;
  localparam int ADS_WIDTH = 255;
  localparam int ADS_CNT_W = 8;

  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } ads_fill_e;
endpackage

// File: rtl/ads_hold_slot.sv
// Output hold register for ads_loader: keeps one completed frame and its valid flag
// until the consumer takes it.
module ads_hold_slot import ads_pkg::*; #(
  parameter int WIDTH = ADS_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_vec,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_vec,
  output logic             out_valid
);

  // load is only raised when the slot is empty or being consumed this cycle,
  // so a load always wins over the consume-driven clear of out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vec   <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_vec   <= load_vec;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ads_loader.sv
// Serial-to-parallel loader for the ads counter: assembles WIDTH bits (bit 0 first)
// into a frame and hands it over through a fill + hold double buffer.
//
// state | meaning
// FILL  | accepting bits into the fill register (s_ready=1)
// STALL | fill holds a complete frame, hold slot still occupied (s_ready=0)
module ads_loader import ads_pkg::*; #(
  parameter int WIDTH = ADS_WIDTH,
  parameter int CNT_W = ADS_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic             s_bit,
  output logic             s_ready,
  input  logic             s_clr,
  output logic [WIDTH-1:0] out_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] fill_cnt
);

  ads_fill_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0] fill_q, fill_d;
  logic             accept;
  logic             consume;
  logic             last;
  logic             load;

  assign s_ready = rst_n && (state_q == FILL);
  assign accept  = s_valid && s_ready;
  assign consume = out_valid && out_ready;
  assign last    = (fill_cnt == CNT_W'(WIDTH - 1));

  // fill_d already contains the bit accepted this cycle, so it doubles as the
  // frame copied into the hold slot on completion.
  always_comb begin
    fill_d = fill_q;
    if (accept && !s_clr) begin
      fill_d[fill_cnt] = s_bit;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = fill_cnt;
    load    = 1'b0;
    if (s_clr) begin
      state_d = FILL;
      cnt_d   = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            if (!last) begin
              cnt_d = fill_cnt + CNT_W'(1);
            end else if (!out_valid || out_ready) begin
              load  = 1'b1;
              cnt_d = '0;
            end else begin
              state_d = STALL;
            end
          end
        end
        STALL: begin
          if (consume) begin
            load    = 1'b1;
            cnt_d   = '0;
            state_d = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      fill_cnt <= '0;
      fill_q   <= '0;
    end else begin
      state_q  <= state_d;
      fill_cnt <= cnt_d;
      fill_q   <= fill_d;
    end
  end

  ads_hold_slot #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_vec  (fill_d),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_valid (out_valid)
  );

endmodule

// File: tb/tb_ads_loader.sv
// Scoreboard bench for ads_loader: driver keeps a frame-level model, monitor pops
// expected frames on every consume and checks the handshake outputs each cycle.
module tb_ads_loader;
  localparam int W = 255;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_valid;
  logic         s_bit;
  logic         s_ready;
  logic         s_clr;
  logic [W-1:0] out_vec;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   fill_cnt;

  ads_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_bit     (s_bit),
    .s_ready   (s_ready),
    .s_clr     (s_clr),
    .out_vec   (out_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fill_cnt  (fill_cnt)
  );

  always #5 clk = ~clk;

  int           n_chk  = 0;
  int           n_fail = 0;
  bit           cur[$];
  logic [W-1:0] exp_q[$];
  int           occ = 0;
  logic         exp_ready = 1'b1;
  logic         exp_valid = 1'b0;
  logic [7:0]   exp_cnt   = 8'd0;
  bit           mon_en    = 1'b0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // One clock cycle of stimulus; model state is advanced for the coming edge.
  task automatic cyc(input bit sv, input bit sb, input bit ordy, input bit clr);
    logic [W-1:0] f;
    bit acc, cons;
    @(posedge clk); #1;
    exp_ready = (occ < 2);
    exp_valid = (occ > 0);
    exp_cnt   = (occ == 2) ? 8'd254 : 8'(cur.size());
    s_valid   = sv;
    s_bit     = sb;
    out_ready = ordy;
    s_clr     = clr;
    acc  = sv && (occ < 2);
    cons = (occ > 0) && ordy;
    if (clr) begin
      cur.delete();
      if (occ == 2) begin
        void'(exp_q.pop_back());
        occ--;
      end
    end else if (acc) begin
      cur.push_back(sb);
      if (cur.size() == W) begin
        for (int k = 0; k < W; k++) f[k] = cur[k];
        exp_q.push_back(f);
        occ++;
        cur.delete();
      end
    end
    if (cons) occ--;
  endtask

  task automatic async_reset();
    @(posedge clk); #1;
    s_valid = 1'b0; s_clr = 1'b0; out_ready = 1'b0;
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", W'(out_valid), W'(1'b0));
    chk("rst_out_vec",   out_vec,       '0);
    chk("rst_fill_cnt",  W'(fill_cnt),  W'(8'd0));
    chk("rst_s_ready",   W'(s_ready),   W'(1'b0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 chk("rst_rel_s_ready", W'(s_ready), W'(1'b1));
    cur.delete(); exp_q.delete(); occ = 0;
    exp_ready = 1'b1; exp_valid = 1'b0; exp_cnt = 8'd0;
    mon_en = 1'b1;
  endtask

  // Monitor: per-cycle handshake checks, stability while held, frame compare on consume.
  logic [W-1:0] prev_vec;
  bit           hold_prev = 1'b0;
  always @(negedge clk) begin
    logic [W-1:0] f;
    if (mon_en) begin
      chk("s_ready",   W'(s_ready),   W'(exp_ready));
      chk("out_valid", W'(out_valid), W'(exp_valid));
      chk("fill_cnt",  W'(fill_cnt),  W'(exp_cnt));
      if (hold_prev) chk("out_vec_stable", out_vec, prev_vec);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL frame: consume seen, expected none pending at %0t", $time);
        end else begin
          f = exp_q.pop_front();
          chk("frame", out_vec, f);
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_vec  = out_vec;
    end else begin
      hold_prev = 1'b0;
    end
  end

  int rp;
  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_bit = 1'b0; s_clr = 1'b0; out_ready = 1'b0;
    #3;
    chk("init_out_valid", W'(out_valid), W'(1'b0));
    chk("init_out_vec",   out_vec,       '0);
    chk("init_fill_cnt",  W'(fill_cnt),  W'(8'd0));
    chk("init_s_ready",   W'(s_ready),   W'(1'b0));
    #9 rst_n = 1'b1;
    mon_en = 1'b1;

    // all ones, consumer always ready
    for (int i = 0; i < W; i++) cyc(1, 1, 1, 0);
    // alternating frame then an all-zero frame back to back
    for (int i = 0; i < W; i++) cyc(1, ((i % 2) == 0), 1, 0);
    for (int i = 0; i < W; i++) cyc(1, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);

    // two frames with no consumer -> stall, then a single-cycle consume
    for (int i = 0; i < 2 * W; i++) cyc(1, 1'($urandom_range(0, 1)), 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);

    // clear after 100 bits, with a same-cycle valid bit that must be dropped
    for (int i = 0; i < 100; i++) cyc(1, 1'($urandom_range(0, 1)), 0, 0);
    cyc(1, 0, 0, 1);
    for (int i = 0; i < W; i++) cyc(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);

    // completion coincides with consume of the previous frame
    for (int i = 0; i < W; i++) cyc(1, 1'($urandom_range(0, 1)), 0, 0);
    for (int i = 0; i < W - 1; i++) cyc(1, 1'($urandom_range(0, 1)), 0, 0);
    cyc(1, 1'($urandom_range(0, 1)), 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);

    // clear while stalled
    for (int i = 0; i < 2 * W; i++) cyc(1, 1'($urandom_range(0, 1)), 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);

    // randomized traffic with varying consumer pressure
    for (int seg = 0; seg < 6; seg++) begin
      case (seg)
        0: rp = 90; 1: rp = 30; 2: rp = 3; 3: rp = 100; 4: rp = 60; default: rp = 1;
      endcase
      for (int i = 0; i < 500; i++)
        cyc($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)),
            $urandom_range(0, 99) < rp, $urandom_range(0, 299) == 0);
    end

    // async reset mid-frame while a frame is held
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 1);
    for (int i = 0; i < W + 37; i++) cyc(1, 1'($urandom_range(0, 1)), 0, 0);
    cyc(0, 0, 0, 0);
    async_reset();

    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 9) < 9, 1'($urandom_range(0, 1)), $urandom_range(0, 99) < 70, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ads_loader.md
# ads_loader

Serial-to-parallel front end for the `ads` population counter. Accepts a 1-bit-per-cycle stream with a valid/ready handshake and assembles exactly 255 bits, bit 0 first, into a frame. It presents each completed frame as a parallel 255-bit vector with a valid/ready handshake that drives the counter's `in` bus directly. A two-slot buffer (fill + hold) lets the next frame be collected while the current one is held for the counter.

## Interface
- `WIDTH`, 255, frame length in bits; must match the counter input width.
- `CNT_W`, 8, width of the fill index; must satisfy 2^CNT_W > WIDTH.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  serial bit present.
- `s_bit`  in  1  serial data bit.
- `s_ready`  out  1  loader can accept a bit this cycle.
- `s_clr`  in  1  discard the partially filled frame (synchronous).
- `out_vec`  out  WIDTH  completed frame; bit i is the i-th accepted bit.
- `out_valid`  out  1  `out_vec` holds an unconsumed frame.
- `out_ready`  in  1  consumer takes the frame.
- `fill_cnt`  out  CNT_W  bits accepted into the current fill frame (0..WIDTH-1).

## Operation
- Input accept: `s_valid && s_ready`. Output consume: `out_valid && out_ready`.
- Fill side has two states:
  - FILL: `s_ready=1`. On accept, write `s_bit` to fill[fill_cnt] and increment `fill_cnt`. On the accept at `fill_cnt==WIDTH-1` (frame complete):
    - If the hold slot is empty, or is being consumed in the same cycle: copy the frame (including the current bit) to hold, set `out_valid=1`, set `fill_cnt=0`, stay in FILL.
    - Otherwise: go to STALL with `fill_cnt` held at WIDTH-1 and the completed frame retained.
  - STALL: `s_ready=0`. On consume: copy fill to hold, keep `out_valid=1`, set `fill_cnt=0`, go to FILL.
- Consume with no transfer in the same cycle: `out_valid` goes to 0. `out_vec` keeps its last value.
- `out_vec` changes only on a transfer. It is stable while `out_valid=1 && out_ready=0`.
- `s_clr`:
  - Sets `fill_cnt=0` and returns to FILL.
  - In STALL, the completed but untransferred frame is discarded.
  - Has priority over a same-cycle accept; that bit is dropped.
  - Never affects the hold slot, `out_valid` or `out_vec`.
- Stale bits left in the fill register after `s_clr` need no clearing; every position is rewritten before the next transfer.
- No word-level arithmetic. `fill_cnt` never wraps past WIDTH-1.

## Timing
- Reset values: `out_valid=0`, `out_vec=0`, `fill_cnt=0`, state FILL. `s_ready=1` once `rst_n` deasserts; `s_ready=0` while `rst_n=0`.
- Reset mid-frame or mid-stall discards the fill and hold contents.
- Latency: `out_valid` rises on the clock edge that accepts bit WIDTH-1; it is visible the following cycle.
- Throughput: one bit per cycle with no bubbles between frames, provided each frame is consumed within WIDTH cycles of being presented.
- `s_ready` deasserts the cycle after STALL is entered. It reasserts the cycle after the consume that releases STALL.
- A consume in the same cycle as frame completion gives a seamless handover: `out_valid` stays 1 and `out_vec` updates to the new frame.
- `s_ready` depends only on registered state; it has no combinational path from `out_ready`.

## Structure
- The shared package `ads_pkg` holds `ADS_WIDTH=255`, `ADS_CNT_W=8` and the fill-side state encoding (FILL, STALL). The `ads` counter and `ads_loader` both take their width from `ads_pkg`.
- One natural sub-module: `ads_hold_slot`, the WIDTH-bit hold register with the out_valid/out_ready logic. The fill register, counter and FSM stay in `ads_loader`.

## Test plan
- Stream 255 ones, `out_ready=1` → one cycle after the last accept, `out_valid=1` and `out_vec` is all ones; the downstream `ads` reports 255.
- Stream the bits 1,0,1,0,… (255 bits), then immediately a second frame of all zeros, `out_ready=1` → frame 1 has `out_vec[0]=1`, `out_vec[1]=0`, `out_vec[254]=1` (popcount 128); frame 2 follows 255 cycles later with popcount 0; `s_ready` never drops.
- `out_ready=0`, stream two full frames → after frame 2 completes, `s_ready=0` and `fill_cnt=254`; frame 1 stays stable. Pulse `out_ready` for 1 cycle → `out_vec` shows frame 2 the next cycle and `s_ready=1` with `fill_cnt=0`.
- Accept 100 bits, then assert `s_clr` with `s_valid=1` → that bit is dropped and `fill_cnt=0`. The next 255 ones produce an all-ones frame; `out_valid` is not affected by the clear.
- Assert `rst_n=0` mid-frame (`fill_cnt=37`) while `out_valid=1` → `out_valid=0`, `out_vec=0`, `fill_cnt=0` immediately, with no clock edge needed.
- Hold `out_ready=1` so that a frame completes in the same cycle as the previous frame's consume → `out_valid` remains 1 continuously and `out_vec` switches on that edge.
